// File: rtl/rfid_bus_sequencer.sv
// rfid_bus_sequencer: programmable Wishbone master running a small command program from RAM
//   clk_i/rst_i          clock, asynchronous active-high reset
//   prog_we/addr/data    program RAM write port (IDLE/ERR only)
//   start, loop_en       run from entry 0; END (or last entry) restarts instead of finishing
//   cyc_o..dat_o, dat_i, ack_i, inta_i   Wishbone master side plus peripheral interrupt
//   dat_i_sel, spi_cs    per-instruction side-band selects
//   rd_data/rd_valid     last captured read data and its update pulse
//   busy, done, err, pc_o   execution status and debug program counter
module rfid_bus_sequencer #(
  parameter int DEPTH = 16,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int NUM_CS = 2,
  parameter int TIMEOUT = 255,
  localparam int PC_W = $clog2(DEPTH),
  localparam int IW = 4 + NUM_CS + ADDR_W + DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [IW-1:0]     prog_data,
  input  logic              start,
  input  logic              loop_en,
  output logic              cyc_o,
  output logic [1:0]        stb_o,
  output logic [ADDR_W-1:0] adr_o,
  output logic              we_o,
  output logic [DATA_W-1:0] dat_o,
  input  logic [DATA_W-1:0] dat_i,
  input  logic              ack_i,
  input  logic              inta_i,
  output logic              dat_i_sel,
  output logic [NUM_CS-1:0] spi_cs,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [PC_W-1:0]   pc_o
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] OP_RD = 2'd1, OP_WAIT = 2'd2, OP_END = 2'd3;
  typedef enum logic [2:0] {IDLE, FETCH, BUS, WAITI, ERR} state_t;
  state_t state, state_n;
  logic [IW-1:0] mem [DEPTH];
  logic [IW-1:0] ins;
  logic [1:0] op;
  logic [PC_W-1:0] pc;
  logic [TW-1:0] tcnt;
  logic trg, rd, go, ld, nxt, fin, tmo, last, hit, idle;
  assign ins = mem[pc];
  assign op = ins[IW-1 -: 2];
  assign last = pc == PC_W'(DEPTH - 1);
  assign idle = state == IDLE || state == ERR;
  assign hit = state == BUS ? ack_i : inta_i;
  assign cyc_o = state == BUS;
  assign stb_o = {cyc_o & ~trg, cyc_o & trg};
  assign we_o = cyc_o & ~rd;
  assign busy = ~idle;
  assign pc_o = pc;
  // go: restart from entry 0, ld: instruction latched, nxt: instruction completed
  always_comb begin
    state_n = state;
    go = 1'b0;
    ld = 1'b0;
    nxt = 1'b0;
    fin = 1'b0;
    tmo = 1'b0;
    case (state)
      IDLE, ERR: begin
        go = start;
        state_n = start ? FETCH : state;
      end
      FETCH: begin
        go = op == OP_END && loop_en;
        fin = op == OP_END && !loop_en;
        ld = op != OP_END;
        state_n = op == OP_END ? (loop_en ? FETCH : IDLE) : (op == OP_WAIT ? WAITI : BUS);
      end
      BUS, WAITI: begin
        // the last entry behaves as if followed by END; pc wraps to 0 for the loop case
        nxt = hit;
        fin = hit && last && !loop_en;
        tmo = !hit && tcnt == TW'(TIMEOUT - 1);
        state_n = hit ? (last && !loop_en ? IDLE : FETCH) : (tmo ? ERR : state);
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc <= '0;
      tcnt <= '0;
      spi_cs <= '0;
      dat_i_sel <= 1'b0;
      trg <= 1'b0;
      rd <= 1'b0;
      adr_o <= '0;
      dat_o <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      pc <= go ? '0 : pc + PC_W'(nxt);
      tcnt <= ld ? '0 : tcnt + TW'(state == BUS || state == WAITI);
      if (ld) begin
        spi_cs <= ins[IW-3 -: NUM_CS];
        dat_i_sel <= ins[ADDR_W+DATA_W+1];
        trg <= ins[ADDR_W+DATA_W];
        rd <= op == OP_RD;
        adr_o <= ins[DATA_W +: ADDR_W];
        dat_o <= ins[DATA_W-1:0];
      end
      rd_valid <= nxt && state == BUS && rd;
      if (nxt && state == BUS && rd) rd_data <= dat_i;
      done <= fin;
      err <= go ? 1'b0 : (tmo ? 1'b1 : err);
    end
  end
  always_ff @(posedge clk_i)
    if (prog_we && idle) mem[prog_addr] <= prog_data;
endmodule

// File: tb/tb_rfid_bus_sequencer.sv
// tb_rfid_bus_sequencer: randomized programs checked against a transaction-level program walk
module tb_rfid_bus_sequencer;
  localparam int TMO = 12;
  logic clk = 0, rst_i = 1;
  logic prog_we = 0, start = 0, loop_en = 0, ack_i = 0, inta_i = 0;
  logic [3:0] prog_addr = 0;
  logic [16:0] prog_data = 0;
  logic [7:0] dat_i = 0;
  logic cyc_o, we_o, dat_i_sel, rd_valid, busy, done, err;
  logic [1:0] stb_o, spi_cs;
  logic [2:0] adr_o;
  logic [7:0] dat_o, rd_data;
  logic [3:0] pc_o;
  logic [16:0] prog [16];
  int n_chk = 0, n_fail = 0;

  rfid_bus_sequencer #(.DEPTH(16), .ADDR_W(3), .DATA_W(8), .NUM_CS(2), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start), .loop_en(loop_en), .cyc_o(cyc_o), .stb_o(stb_o), .adr_o(adr_o), .we_o(we_o),
    .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .inta_i(inta_i), .dat_i_sel(dat_i_sel),
    .spi_cs(spi_cs), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
    .err(err), .pc_o(pc_o));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] mk(input int op, input int cs, input int sel, input int trg,
                                     input int adr, input int dat);
    return {op[1:0], cs[1:0], sel[0], trg[0], adr[2:0], dat[7:0]};
  endfunction

  task automatic load(input int a, input logic [16:0] w);
    prog_we = 1; prog_addr = a[3:0]; prog_data = w;
    tick();
    prog_we = 0;
    prog[a] = w;
  endtask

  function automatic logic [16:0] rnd_ins(input bit no_end);
    int r, op;
    r = $urandom_range(0, 9);
    op = r < 4 ? 0 : r < 7 ? 1 : r < 8 ? 2 : (no_end ? 1 : 3);
    return mk(op, $urandom, $urandom, $urandom, $urandom, $urandom);
  endfunction

  task automatic gen_prog(input bit no_end);
    for (int i = 0; i < 16; i++) load(i, rnd_ins(no_end));
  endtask

  function automatic int pick_dly();
    return $urandom_range(0, 5) == 5 ? TMO - 1 : $urandom_range(0, 3);
  endfunction

  // Runs the loaded program once (loop_en=0) with a randomized slave and compares every
  // acknowledged transfer with the list of bus instructions the program walk predicts.
  task automatic execute(input bit wr0, input logic [16:0] w0, input int fixed_dly);
    int q[$];
    int dly, clen, wcnt, wdly, last_pc, idx, exp_pc;
    bit rdp, seen_done, inta_chk;
    logic [7:0] rexp;
    logic [16:0] w;
    if (wr0) begin
      prog_we = 1; prog_addr = 0; prog_data = w0; prog[0] = w0;
    end
    for (int i = 0; i < 16; i++) begin
      if (prog[i][16:15] == 2'd3) break;
      if (prog[i][16:15] < 2'd2) q.push_back(i);
    end
    start = 1;
    tick();
    start = 0; prog_we = 0;
    check("busy_go", busy, 1);
    check("err_clr", err, 0);
    dly = fixed_dly < 0 ? pick_dly() : fixed_dly;
    clen = 0; wcnt = -1; wdly = $urandom_range(1, TMO); last_pc = pc_o;
    rdp = 0; seen_done = 0; inta_chk = 0; rexp = 0; exp_pc = 0;
    for (int c = 0; c < 3000 && !seen_done; c++) begin
      ack_i = 0; prog_we = 0;
      if (rdp) begin
        check("rd_valid", rd_valid, 1);
        check("rd_data", rd_data, rexp);
        rdp = 0;
      end else check("rd_valid_lo", rd_valid, 0);
      if (inta_chk) begin
        check("inta_pc", pc_o, exp_pc);
        inta_chk = 0;
      end
      if (pc_o != last_pc) begin
        last_pc = pc_o; wcnt = 0; wdly = $urandom_range(1, TMO); inta_i = 0;
      end else wcnt++;
      if (done) seen_done = 1;
      else begin
        if (c == 2 && busy) begin
          prog_we = 1; prog_addr = $urandom; prog_data = $urandom;
        end
        if (cyc_o) begin
          clen++;
          if (clen == dly + 1) begin
            check("txn_q", q.size() != 0, 1);
            if (q.size() != 0) begin
              idx = q.pop_front();
              w = prog[idx];
              check("txn_pc", pc_o, idx);
              check("adr_o", adr_o, w[10:8]);
              check("dat_o", dat_o, w[7:0]);
              check("we_o", we_o, w[16:15] == 2'd0);
              check("stb_o", stb_o, w[11] ? 2'b01 : 2'b10);
              check("spi_cs", spi_cs, w[14:13]);
              check("dat_i_sel", dat_i_sel, w[12]);
              ack_i = 1; dat_i = $urandom;
              if (w[16:15] == 2'd1) begin
                rdp = 1; rexp = dat_i;
              end
            end
            clen = 0;
            dly = fixed_dly < 0 ? pick_dly() : fixed_dly;
          end
        end else clen = 0;
        if (busy && !cyc_o && prog[pc_o][16:15] == 2'd2 && wcnt >= wdly && !inta_i) begin
          inta_i = 1; inta_chk = 1; exp_pc = (pc_o + 1) % 16;
        end
      end
      tick();
    end
    ack_i = 0; inta_i = 0; prog_we = 0;
    check("done_seen", seen_done, 1);
    check("txn_all", q.size(), 0);
    check("err_end", err, 0);
    check("done_pulse", done, 0);
    check("busy_end", busy, 0);
  endtask

  initial begin
    int n, nd, na, wraps, lp;
    bit seen;
    repeat (3) tick();
    check("rst_cyc", cyc_o, 0);
    check("rst_stb", stb_o, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rdv", rd_valid, 0);
    check("rst_pc", pc_o, 0);
    check("rst_out", {adr_o, dat_o, spi_cs, we_o, dat_i_sel}, 0);
    rst_i = 0;
    tick();
    // basic write then END, slave acks after two wait cycles
    load(0, mk(0, 3, 0, 0, 0, 8'h50));
    for (int i = 1; i < 16; i++) load(i, mk(3, 0, 0, 0, 0, 0));
    execute(0, 0, 2);
    // read from target1 address 5
    load(0, mk(1, 0, 1, 1, 5, 0));
    execute(0, 0, 1);
    // wait for interrupt followed by a write
    load(0, mk(2, 1, 0, 0, 0, 0));
    load(1, mk(0, 2, 1, 1, 7, 8'hC3));
    execute(0, 0, -1);
    // random programs, some replacing entry 0 in the same cycle as start
    for (int r = 0; r < 8; r++) begin
      gen_prog(0);
      execute(r[0], rnd_ins(0), -1);
    end
    // all 16 entries without END
    for (int r = 0; r < 2; r++) begin
      gen_prog(1);
      execute(0, 0, -1);
    end
    // timeout on a never-acked write, then restart from ERR
    load(0, mk(0, 1, 0, 1, 2, 8'h11));
    load(1, mk(3, 0, 0, 0, 0, 0));
    start = 1;
    tick();
    start = 0;
    n = 0;
    for (int c = 0; c < 60; c++) begin
      if (cyc_o) n++;
      else if (n > 0) break;
      tick();
    end
    check("tmo_len", n, TMO);
    check("tmo_err", err, 1);
    check("tmo_busy", busy, 0);
    ack_i = 1;
    tick();
    ack_i = 0;
    check("tmo_ack_ign", {busy, err}, 2'b01);
    execute(0, 0, -1);
    // looping [WRITE, END]
    loop_en = 1;
    start = 1;
    tick();
    start = 0;
    nd = 0; na = 0; wraps = 0; lp = pc_o;
    for (int c = 0; c < 60; c++) begin
      ack_i = 0;
      if (done) nd++;
      if (pc_o == 0 && lp == 1) wraps++;
      lp = pc_o;
      if (cyc_o) begin
        ack_i = 1; na++;
      end
      tick();
    end
    check("loop_nodone", nd, 0);
    check("loop_writes", na >= 10, 1);
    check("loop_wraps", wraps >= 10, 1);
    check("loop_busy", busy, 1);
    loop_en = 0;
    seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      ack_i = 0;
      if (done) seen = 1;
      else if (cyc_o) ack_i = 1;
      tick();
    end
    ack_i = 0;
    check("loop_exit_done", seen, 1);
    check("loop_exit_busy", busy, 0);
    // asynchronous reset in the middle of the second bus cycle
    load(0, mk(0, 2, 0, 0, 3, 8'h21));
    load(1, mk(1, 1, 1, 1, 6, 0));
    for (int i = 2; i < 16; i++) load(i, mk(3, 0, 0, 0, 0, 0));
    start = 1;
    tick();
    start = 0;
    for (int c = 0; c < 40; c++) begin
      ack_i = 0;
      if (cyc_o && pc_o == 1) break;
      if (cyc_o) ack_i = 1;
      tick();
    end
    check("pre_rst_cyc", cyc_o, 1);
    rst_i = 1;
    #1;
    check("arst_cyc", cyc_o, 0);
    check("arst_busy", busy, 0);
    check("arst_pc", pc_o, 0);
    tick();
    rst_i = 0;
    tick();
    execute(0, 0, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
